// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: serialises mapper PRG/CHR byte requests onto one
// single-port cartridge memory with round-robin grant and a watchdog.
module cart_mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 22
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce,

    input  logic [AW-1:0] prg_addr,
    input  logic          prg_read,
    input  logic          prg_write,
    input  logic          prg_allow,
    input  logic [7:0]    prg_wdata,
    output logic [7:0]    prg_rdata,
    output logic          prg_done,

    input  logic [AW-1:0] chr_addr,
    input  logic          chr_read,
    input  logic          chr_write,
    input  logic          chr_allow,
    input  logic [7:0]    chr_wdata,
    output logic [7:0]    chr_rdata,
    output logic          chr_done,

    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,

    output logic          busy,
    output logic          overflow,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic       SIDE_PRG = 1'b0;
    localparam logic       SIDE_CHR = 1'b1;
    localparam logic [9:0] WD_LAST  = 10'(TIMEOUT - 1);

    state_t        state;
    logic          last_grant;
    logic          cur_side;
    logic [9:0]    wdog;

    logic          prg_pend;
    logic          prg_we_q;
    logic [AW-1:0] prg_addr_q;
    logic [7:0]    prg_wdata_q;

    logic          chr_pend;
    logic          chr_we_q;
    logic [AW-1:0] chr_addr_q;
    logic [7:0]    chr_wdata_q;

    logic          prg_cap;
    logic          prg_cap_we;
    logic          chr_cap;
    logic          chr_cap_we;
    logic          grant_prg;
    logic          grant_chr;

    // A write only counts when the mapper allows it; a blocked write
    // still lets a simultaneous read through.
    always_comb begin
        prg_cap_we = prg_write & prg_allow;
        prg_cap    = ce & (prg_read | prg_cap_we);
        chr_cap_we = chr_write & chr_allow;
        chr_cap    = ce & (chr_read | chr_cap_we);
        grant_prg  = (state == IDLE) & prg_pend
                   & (~chr_pend | (last_grant == SIDE_CHR));
        grant_chr  = (state == IDLE) & chr_pend & ~grant_prg;
    end

    assign busy = (state != IDLE) | prg_pend | chr_pend;

    // Pending slots. A slot leaving for the memory this cycle is not
    // overwritten, so a same-cycle capture refills it without overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prg_pend    <= 1'b0;
            prg_we_q    <= 1'b0;
            prg_addr_q  <= '0;
            prg_wdata_q <= '0;
            chr_pend    <= 1'b0;
            chr_we_q    <= 1'b0;
            chr_addr_q  <= '0;
            chr_wdata_q <= '0;
            overflow    <= 1'b0;
        end else begin
            if (prg_cap) begin
                prg_pend    <= 1'b1;
                prg_we_q    <= prg_cap_we;
                prg_addr_q  <= prg_addr;
                prg_wdata_q <= prg_wdata;
                if (prg_pend && !grant_prg) begin
                    overflow <= 1'b1;
                end
            end else if (grant_prg) begin
                prg_pend <= 1'b0;
            end

            if (chr_cap) begin
                chr_pend    <= 1'b1;
                chr_we_q    <= chr_cap_we;
                chr_addr_q  <= chr_addr;
                chr_wdata_q <= chr_wdata;
                if (chr_pend && !grant_chr) begin
                    overflow <= 1'b1;
                end
            end else if (grant_chr) begin
                chr_pend <= 1'b0;
            end
        end
    end

    // ISSUE is the first cycle mem_req is high; WAIT covers the rest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= SIDE_CHR;
            cur_side    <= SIDE_PRG;
            wdog        <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            prg_rdata   <= '0;
            chr_rdata   <= '0;
            prg_done    <= 1'b0;
            chr_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            prg_done <= 1'b0;
            chr_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_prg || grant_chr) begin
                        state    <= ISSUE;
                        mem_req  <= 1'b1;
                        cur_side <= grant_chr;
                        wdog     <= '0;
                        if (grant_chr) begin
                            mem_we    <= chr_we_q;
                            mem_addr  <= chr_addr_q;
                            mem_wdata <= chr_wdata_q;
                        end else begin
                            mem_we    <= prg_we_q;
                            mem_addr  <= prg_addr_q;
                            mem_wdata <= prg_wdata_q;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (mem_ack || wdog == WD_LAST) begin
                        state      <= IDLE;
                        mem_req    <= 1'b0;
                        last_grant <= cur_side;
                        if (cur_side == SIDE_CHR) begin
                            chr_done <= 1'b1;
                        end else begin
                            prg_done <= 1'b1;
                        end
                        if (!mem_ack) begin
                            timeout_err <= 1'b1;
                        end else if (!mem_we) begin
                            if (cur_side == SIDE_CHR) begin
                                chr_rdata <= mem_rdata;
                            end else begin
                                prg_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        state <= WAIT;
                        wdog  <= wdog + 10'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// tb_cart_mem_arbiter: scoreboard bench for cart_mem_arbiter
// (TIMEOUT=8) with a scripted memory responder.
module tb_cart_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic [21:0] prg_addr = '0;
    logic        prg_read = 1'b0;
    logic        prg_write = 1'b0;
    logic        prg_allow = 1'b0;
    logic [7:0]  prg_wdata = '0;
    logic [7:0]  prg_rdata;
    logic        prg_done;
    logic [21:0] chr_addr = '0;
    logic        chr_read = 1'b0;
    logic        chr_write = 1'b0;
    logic        chr_allow = 1'b0;
    logic [7:0]  chr_wdata = '0;
    logic [7:0]  chr_rdata;
    logic        chr_done;
    logic        mem_req;
    logic        mem_we;
    logic [21:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'hEE;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        chr;
        logic        we;
        logic [21:0] addr;
        logic [7:0]  wd;
    } exp_t;

    exp_t sb[$];
    logic [7:0] exp_prg_rdata = 8'h00;
    logic [7:0] exp_chr_rdata = 8'h00;

    cart_mem_arbiter #(.TIMEOUT(8), .AW(22)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .prg_addr(prg_addr), .prg_read(prg_read),
        .prg_write(prg_write), .prg_allow(prg_allow),
        .prg_wdata(prg_wdata), .prg_rdata(prg_rdata),
        .prg_done(prg_done),
        .chr_addr(chr_addr), .chr_read(chr_read),
        .chr_write(chr_write), .chr_allow(chr_allow),
        .chr_wdata(chr_wdata), .chr_rdata(chr_rdata),
        .chr_done(chr_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .busy(busy), .overflow(overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic pr, input logic pw, input logic pa,
        input logic [21:0] padr, input logic [7:0] pwd,
        input logic cr, input logic cw, input logic ca,
        input logic [21:0] cadr, input logic [7:0] cwd,
        input logic c
    );
        prg_read = pr; prg_write = pw; prg_allow = pa;
        prg_addr = padr; prg_wdata = pwd;
        chr_read = cr; chr_write = cw; chr_allow = ca;
        chr_addr = cadr; chr_wdata = cwd;
        ce = c;
        tick();
        prg_read = 1'b0; prg_write = 1'b0; prg_allow = 1'b0;
        chr_read = 1'b0; chr_write = 1'b0; chr_allow = 1'b0;
        ce = 1'b1;
    endtask

    task automatic push(input logic c, input logic w,
                        input logic [21:0] a, input logic [7:0] d);
        exp_t e;
        e.chr = c; e.we = w; e.addr = a; e.wd = d;
        sb.push_back(e);
    endtask

    task automatic pop(output exp_t e);
        if (sb.size() == 0) begin
            e.chr = 1'bx; e.we = 1'bx; e.addr = 'x; e.wd = 'x;
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Memory responder: waits for mem_req, acks after lat cycles
    // (lat=0: never), and records what it observed.
    task automatic mem_cycle(
        input int lat, input logic [7:0] rd,
        output logic got, output int waitc,
        output logic we, output logic [21:0] a,
        output logic [7:0] wd, output int req_cyc,
        output logic stable, output logic pd, output logic cd
    );
        bit fin = 0;
        waitc = 0;
        while (!mem_req && waitc < 20) begin
            tick();
            waitc++;
        end
        got = mem_req;
        we = mem_we; a = mem_addr; wd = mem_wdata;
        req_cyc = 0; stable = 1'b1;
        while (got && !fin && req_cyc < 100) begin
            req_cyc++;
            if (lat != 0 && req_cyc == lat) begin
                mem_ack = 1'b1;
                mem_rdata = rd;
            end
            tick();
            mem_ack = 1'b0;
            mem_rdata = 8'hEE;
            if (lat != 0 && req_cyc == lat) fin = 1;
            else if (!mem_req) fin = 1;
            else if (mem_addr !== a || mem_we !== we
                     || mem_wdata !== wd) stable = 1'b0;
        end
        pd = prg_done;
        cd = chr_done;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got %b %b %h %h want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_tests++;
        if ({prg_rdata, chr_rdata, prg_done, chr_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_side: got %h %h %b %b want all 0",
                     prg_rdata, chr_rdata, prg_done, chr_done);
        end
        reset_n = 1'b1;
        tick();
        n_tests++;
        if ({busy, overflow, timeout_err, mem_req} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b%b%b%b want 0000",
                     busy, overflow, timeout_err, mem_req);
        end
    endtask

    task automatic test_arb_prg_first();
        logic g, w, p, c, s; logic [21:0] a; logic [7:0] d;
        int wc, rc; exp_t e;
        push(1'b0, 1'b1, 22'h000100, 8'h3C);
        push(1'b1, 1'b0, 22'h001234, 8'h00);
        drive(0, 1, 1, 22'h000100, 8'h3C,
              1, 0, 0, 22'h001234, 8'h00, 1);
        for (int i = 0; i < 2; i++) begin
            mem_cycle(i + 1, 8'h5A, g, wc, w, a, d, rc, s, p, c);
            pop(e);
            n_tests++;
            if ({g, w, a, d, p, c, s}
                !== {1'b1, e.we, e.addr, e.wd, ~e.chr, e.chr, 1'b1}) begin
                n_fail++;
                $display("FAIL arb_prg_first[%0d]: got %b %b %h %h %b%b %b want 1 %b %h %h %b%b 1",
                         i, g, w, a, d, p, c, s,
                         e.we, e.addr, e.wd, ~e.chr, e.chr);
            end
        end
        exp_chr_rdata = 8'h5A;
        n_tests++;
        if ({chr_rdata, prg_rdata} !== {exp_chr_rdata, exp_prg_rdata}) begin
            n_fail++;
            $display("FAIL arb_prg_first_rdata: got %h %h want %h %h",
                     chr_rdata, prg_rdata, exp_chr_rdata, exp_prg_rdata);
        end
    endtask

    task automatic test_prg_read();
        logic g, w, p, c, s; logic [21:0] a; logic [7:0] d;
        int wc, rc; exp_t e;
        push(1'b0, 1'b0, 22'h012345, 8'h00);
        drive(1, 0, 0, 22'h012345, 8'h00,
              0, 0, 0, 22'h0, 8'h00, 1);
        mem_cycle(3, 8'hA5, g, wc, w, a, d, rc, s, p, c);
        pop(e);
        exp_prg_rdata = 8'hA5;
        n_tests++;
        if ({g, w, a, p, c} !== {1'b1, e.we, e.addr, 2'b10}) begin
            n_fail++;
            $display("FAIL prg_read_xfer: got %b %b %h %b%b want 1 %b %h 10",
                     g, w, a, p, c, e.we, e.addr);
        end
        n_tests++;
        if (rc !== 3 || s !== 1'b1 || wc !== 1) begin
            n_fail++;
            $display("FAIL prg_read_timing: got req=%0d stable=%b wait=%0d want 3 1 1",
                     rc, s, wc);
        end
        n_tests++;
        if (prg_rdata !== exp_prg_rdata) begin
            n_fail++;
            $display("FAIL prg_read_rdata: got %h want %h",
                     prg_rdata, exp_prg_rdata);
        end
        tick();
        n_tests++;
        if ({prg_done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL prg_read_pulse: got done=%b busy=%b want 0 0",
                     prg_done, busy);
        end
    endtask

    task automatic test_arb_chr_first();
        logic g, w, p, c, s; logic [21:0] a; logic [7:0] d;
        int wc, rc; exp_t e;
        push(1'b1, 1'b1, 22'h002000, 8'h77);
        push(1'b0, 1'b0, 22'h0000FF, 8'h00);
        drive(1, 0, 0, 22'h0000FF, 8'h00,
              0, 1, 1, 22'h002000, 8'h77, 1);
        for (int i = 0; i < 2; i++) begin
            mem_cycle(1, 8'h11, g, wc, w, a, d, rc, s, p, c);
            pop(e);
            n_tests++;
            if ({g, w, a, d, p, c}
                !== {1'b1, e.we, e.addr, e.wd, ~e.chr, e.chr}) begin
                n_fail++;
                $display("FAIL arb_chr_first[%0d]: got %b %b %h %h %b%b want 1 %b %h %h %b%b",
                         i, g, w, a, d, p, c,
                         e.we, e.addr, e.wd, ~e.chr, e.chr);
            end
        end
        exp_prg_rdata = 8'h11;
        n_tests++;
        if ({chr_rdata, prg_rdata} !== {exp_chr_rdata, exp_prg_rdata}) begin
            n_fail++;
            $display("FAIL arb_chr_first_rdata: got %h %h want %h %h",
                     chr_rdata, prg_rdata, exp_chr_rdata, exp_prg_rdata);
        end
    endtask

    task automatic test_disallowed();
        logic saw_req = 1'b0, saw_done = 1'b0, saw_busy = 1'b0;
        drive(0, 1, 0, 22'h000300, 8'h99,
              0, 1, 0, 22'h000400, 8'h98, 1);
        drive(1, 0, 0, 22'h000042, 8'h00,
              1, 0, 0, 22'h000043, 8'h00, 0);
        for (int i = 0; i < 6; i++) begin
            saw_req  |= mem_req;
            saw_done |= prg_done | chr_done;
            saw_busy |= busy;
            tick();
        end
        n_tests++;
        if ({saw_req, saw_done, saw_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL disallowed: got req=%b done=%b busy=%b want 0 0 0",
                     saw_req, saw_done, saw_busy);
        end
    endtask

    task automatic test_overflow();
        logic g, w, p, c, s; logic [21:0] a; logic [7:0] d;
        logic g2, w2, p2, c2, s2; logic [21:0] a2; logic [7:0] d2;
        int wc, rc, wc2, rc2; exp_t e;
        logic saw_req = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_pre: got %b want 0", overflow);
        end
        push(1'b1, 1'b0, 22'h000500, 8'h00);
        push(1'b0, 1'b0, 22'h000020, 8'h00);
        drive(0, 0, 0, 22'h0, 8'h00,
              1, 0, 0, 22'h000500, 8'h00, 1);
        fork
            mem_cycle(5, 8'h6B, g, wc, w, a, d, rc, s, p, c);
            begin
                tick(); tick();
                drive(1, 0, 0, 22'h000010, 8'h00,
                      0, 0, 0, 22'h0, 8'h00, 1);
                drive(1, 0, 0, 22'h000020, 8'h00,
                      0, 0, 0, 22'h0, 8'h00, 1);
            end
        join
        exp_chr_rdata = 8'h6B;
        pop(e);
        n_tests++;
        if ({g, a, p, c, rc, s} !== {1'b1, e.addr, 2'b01, 32'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow_chr: got %b %h %b%b req=%0d st=%b want 1 %h 01 5 1",
                     g, a, p, c, rc, s, e.addr);
        end
        n_tests++;
        if ({overflow, chr_rdata} !== {1'b1, exp_chr_rdata}) begin
            n_fail++;
            $display("FAIL overflow_flag: got %b %h want 1 %h",
                     overflow, chr_rdata, exp_chr_rdata);
        end
        mem_cycle(1, 8'hC3, g2, wc2, w2, a2, d2, rc2, s2, p2, c2);
        pop(e);
        exp_prg_rdata = 8'hC3;
        n_tests++;
        if ({g2, w2, a2, p2, c2, prg_rdata}
            !== {1'b1, e.we, e.addr, 2'b10, exp_prg_rdata}) begin
            n_fail++;
            $display("FAIL overflow_prg: got %b %b %h %b%b %h want 1 %b %h 10 %h",
                     g2, w2, a2, p2, c2, prg_rdata,
                     e.we, e.addr, exp_prg_rdata);
        end
        for (int i = 0; i < 5; i++) begin
            saw_req |= mem_req;
            tick();
        end
        n_tests++;
        if ({saw_req, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL overflow_dropped: got req=%b busy=%b want 0 0",
                     saw_req, busy);
        end
    endtask

    task automatic test_timeout();
        logic g, w, p, c, s; logic [21:0] a; logic [7:0] d;
        int wc, rc; exp_t e;
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pre: got %b want 0", timeout_err);
        end
        push(1'b0, 1'b0, 22'h000777, 8'h00);
        drive(1, 0, 0, 22'h000777, 8'h00,
              0, 0, 0, 22'h0, 8'h00, 1);
        mem_cycle(0, 8'h00, g, wc, w, a, d, rc, s, p, c);
        pop(e);
        n_tests++;
        if ({g, a, rc, s, p, c} !== {1'b1, e.addr, 32'd8, 1'b1, 2'b10}) begin
            n_fail++;
            $display("FAIL timeout_xfer: got %b %h req=%0d st=%b %b%b want 1 %h 8 1 10",
                     g, a, rc, s, p, c, e.addr);
        end
        n_tests++;
        if ({timeout_err, mem_req, prg_rdata}
            !== {2'b10, exp_prg_rdata}) begin
            n_fail++;
            $display("FAIL timeout_state: got err=%b req=%b rd=%h want 1 0 %h",
                     timeout_err, mem_req, prg_rdata, exp_prg_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic g, w, p, c, s; logic [21:0] a; logic [7:0] d;
        int wc, rc, n; exp_t e;
        drive(0, 0, 0, 22'h0, 8'h00,
              1, 0, 0, 22'h003333, 8'h00, 1);
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        tick(); tick();
        n_tests++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got req=%b want 1", mem_req);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({mem_req, busy, overflow, timeout_err, prg_done, chr_done}
            !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b%b%b%b%b%b want 000000",
                     mem_req, busy, overflow, timeout_err,
                     prg_done, chr_done);
        end
        tick(); tick();
        reset_n = 1'b1;
        exp_prg_rdata = 8'h00;
        exp_chr_rdata = 8'h00;
        tick();
        push(1'b0, 1'b0, 22'h000055, 8'h00);
        drive(1, 0, 0, 22'h000055, 8'h00,
              0, 0, 0, 22'h0, 8'h00, 1);
        mem_cycle(2, 8'h99, g, wc, w, a, d, rc, s, p, c);
        pop(e);
        exp_prg_rdata = 8'h99;
        n_tests++;
        if ({g, w, a, p, c, rc, prg_rdata, chr_rdata}
            !== {1'b1, e.we, e.addr, 2'b10, 32'd2,
                 exp_prg_rdata, exp_chr_rdata}) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %b %b %h %b%b req=%0d %h %h want 1 %b %h 10 2 %h %h",
                     g, w, a, p, c, rc, prg_rdata, chr_rdata,
                     e.we, e.addr, exp_prg_rdata, exp_chr_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_arb_prg_first();
        test_prg_read();
        test_arb_chr_first();
        test_disallowed();
        test_overflow();
        test_timeout();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: got %0d entries want 0",
                     sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
